// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register divide scoreboard with forwarding, stall and flush control
// Optional feature macro: HAZARD_PERF_CNT_EN (stall/flush performance counters)
// Ports:
//   clk, rst                          clock, async active-high reset
//   rs1_d, rs2_d, rd_d, *_used_d      ID-stage operands and destination
//   reg_write_d, div_d                ID writes rd_d / ID instruction is a divide
//   rd_e, rs1_e, rs2_e, *_used_e      EX-stage registers
//   load_e, div_issue_e, branch_taken EX load / divide launch / redirect
//   rd_m, rd_w, reg_write_m/w         MEM/WB destinations
//   div_wb_valid, div_wb_rd           divider retire port
//   stall, flush                      pipeline control
//   fwd_rs1, fwd_rs2                  00 regfile, 10 MEM, 01 WB, 11 divider
//   busy, div_full, sb_err            scoreboard state, divider full, sticky protocol error
//   stall_cnt, flush_cnt              perf counters (zero when feature disabled)
module hazard_scoreboard #(
    parameter int AW      = 5,
    parameter int MAX_OUT = 2,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    rs1_d,
    input  logic [AW-1:0]    rs2_d,
    input  logic [AW-1:0]    rd_d,
    input  logic             rs1_used_d,
    input  logic             rs2_used_d,
    input  logic             reg_write_d,
    input  logic             div_d,
    input  logic [AW-1:0]    rd_e,
    input  logic [AW-1:0]    rs1_e,
    input  logic [AW-1:0]    rs2_e,
    input  logic             rs1_used_e,
    input  logic             rs2_used_e,
    input  logic             load_e,
    input  logic             div_issue_e,
    input  logic             branch_taken,
    input  logic [AW-1:0]    rd_m,
    input  logic [AW-1:0]    rd_w,
    input  logic             reg_write_m,
    input  logic             reg_write_w,
    input  logic             div_wb_valid,
    input  logic [AW-1:0]    div_wb_rd,
    output logic             stall,
    output logic             flush,
    output logic [1:0]       fwd_rs1,
    output logic [1:0]       fwd_rs2,
    output logic [2**AW-1:0] busy,
    output logic             div_full,
    output logic             sb_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int NREGS = 2**AW;

    logic [NREGS-1:0] busy_nxt;
    logic [2:0]       out_cnt;
    logic             err_now;
    logic             raw_e;

    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] rs, input logic used);
        return (!used || rs == '0)                  ? 2'b00 :
               (reg_write_m && rd_m == rs)          ? 2'b10 :
               (reg_write_w && rd_w == rs)          ? 2'b01 :
               (div_wb_valid && div_wb_rd == rs)    ? 2'b11 : 2'b00;
    endfunction

    // Set is applied after clear so a same-cycle issue to a retiring register keeps it busy.
    always_comb begin
        busy_nxt = busy;
        if (div_wb_valid) busy_nxt[div_wb_rd] = 1'b0;
        if (div_issue_e && rd_e != '0) busy_nxt[rd_e] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    assign div_full = out_cnt == 3'(MAX_OUT);
    assign err_now  = (div_wb_valid && (out_cnt == 3'd0 || (div_wb_rd != '0 && !busy[div_wb_rd])))
                   || (div_issue_e && div_full && !div_wb_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= '0;
            out_cnt <= '0;
            sb_err  <= 1'b0;
        end else begin
            busy    <= busy_nxt;
            out_cnt <= out_cnt + 3'(div_issue_e) - 3'(div_wb_valid);
            sb_err  <= sb_err | err_now;
        end
    end

    always_comb begin
        fwd_rs1 = fwd_sel(rs1_e, rs1_used_e);
        fwd_rs2 = fwd_sel(rs2_e, rs2_used_e);
    end

    assign raw_e = rd_e != '0 && ((rs1_used_d && rs1_d == rd_e) || (rs2_used_d && rs2_d == rd_e));

    // Stall reads the registered busy vector, so a retiring divide releases its consumers one cycle later.
    assign stall = ((load_e || div_issue_e) && raw_e)
                || (rs1_used_d && busy[rs1_d])
                || (rs2_used_d && busy[rs2_d])
                || (reg_write_d && rd_d != '0 && busy[rd_d])
                || (div_d && div_full);
    assign flush = branch_taken;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + CNT_W'(stall);
            flush_cnt <= flush_cnt + CNT_W'(flush);
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus randomized run against a queue-based reference model
module tb_hazard_scoreboard;
    localparam int AW   = 5;
    localparam int MAXO = 2;
    localparam int CW   = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [AW-1:0] rs1_d, rs2_d, rd_d, rd_e, rs1_e, rs2_e, rd_m, rd_w, div_wb_rd;
    logic rs1_used_d, rs2_used_d, reg_write_d, div_d, rs1_used_e, rs2_used_e;
    logic load_e, div_issue_e, branch_taken, reg_write_m, reg_write_w, div_wb_valid;
    logic stall, flush, div_full, sb_err;
    logic [1:0] fwd_rs1, fwd_rs2;
    logic [2**AW-1:0] busy;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_chk = 0;
    int n_fail = 0;
    int pend[$];

    always #5 clk = ~clk;

    hazard_scoreboard #(.AW(AW), .MAX_OUT(MAXO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .rs1_used_d(rs1_used_d), .rs2_used_d(rs2_used_d),
        .reg_write_d(reg_write_d), .div_d(div_d),
        .rd_e(rd_e), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rs1_used_e(rs1_used_e), .rs2_used_e(rs2_used_e),
        .load_e(load_e), .div_issue_e(div_issue_e), .branch_taken(branch_taken),
        .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .div_wb_valid(div_wb_valid), .div_wb_rd(div_wb_rd),
        .stall(stall), .flush(flush), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
        .busy(busy), .div_full(div_full), .sb_err(sb_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic idle();
        {rs1_d, rs2_d, rd_d, rd_e, rs1_e, rs2_e, rd_m, rd_w, div_wb_rd} = '0;
        {rs1_used_d, rs2_used_d, reg_write_d, div_d, rs1_used_e, rs2_used_e} = '0;
        {load_e, div_issue_e, branch_taken, reg_write_m, reg_write_w, div_wb_valid} = '0;
    endtask

    // Called at a negedge; returns at the following negedge with reset released.
    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pend.delete();
    endtask

    task automatic issue(input logic [AW-1:0] r);
        idle();
        div_issue_e = 1'b1;
        rd_e = r;
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        #1;
        n_chk++; if (busy !== '0) begin n_fail++; $display("FAIL reset_busy got %h exp 0", busy); end
        n_chk++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL reset_sb_err got %b exp 0", sb_err); end
        n_chk++; if (div_full !== 1'b0) begin n_fail++; $display("FAIL reset_div_full got %b exp 0", div_full); end
        n_chk++; if (stall !== 1'b0 || flush !== 1'b0) begin n_fail++; $display("FAIL reset_ctl got %b%b exp 00", stall, flush); end
        n_chk++; if (stall_cnt !== '0 || flush_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_div_raw();
        do_reset();
        issue(5);
        rs1_d = 5; rs1_used_d = 1'b1; reg_write_d = 1'b1; rd_d = 6;
        #1;
        n_chk++; if (busy !== 32'h20) begin n_fail++; $display("FAIL raw_busy got %h exp 00000020", busy); end
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL raw_hold%0d got %b exp 1", i, stall); end
            @(negedge clk); #1;
        end
        div_wb_valid = 1'b1; div_wb_rd = 5;
        #1;
        n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL raw_wb_cycle got %b exp 1", stall); end
        @(negedge clk);
        div_wb_valid = 1'b0;
        #1;
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_release got %b exp 0", stall); end
        n_chk++; if (busy !== '0) begin n_fail++; $display("FAIL raw_busy_clr got %h exp 0", busy); end
        @(negedge clk);
    endtask

    task automatic test_fwd();
        do_reset();
        issue(7);
        div_wb_valid = 1'b1; div_wb_rd = 7; rs2_e = 7; rs2_used_e = 1'b1; rs1_e = 7;
        rd_m = 3; reg_write_m = 1'b1; rd_w = 4; reg_write_w = 1'b1;
        #1;
        n_chk++; if (fwd_rs2 !== 2'b11) begin n_fail++; $display("FAIL fwd_div got %b exp 11", fwd_rs2); end
        n_chk++; if (fwd_rs1 !== 2'b00) begin n_fail++; $display("FAIL fwd_unused got %b exp 00", fwd_rs1); end
        rd_m = 7; #1;
        n_chk++; if (fwd_rs2 !== 2'b10) begin n_fail++; $display("FAIL fwd_mem got %b exp 10", fwd_rs2); end
        rd_m = 3; rd_w = 7; #1;
        n_chk++; if (fwd_rs2 !== 2'b01) begin n_fail++; $display("FAIL fwd_wb got %b exp 01", fwd_rs2); end
        rd_w = 7; reg_write_w = 1'b0; rd_m = 7; reg_write_m = 1'b0; #1;
        n_chk++; if (fwd_rs2 !== 2'b11) begin n_fail++; $display("FAIL fwd_nowrite got %b exp 11", fwd_rs2); end
        rs2_e = 0; div_wb_rd = 0; rd_m = 0; reg_write_m = 1'b1; #1;
        n_chk++; if (fwd_rs2 !== 2'b00) begin n_fail++; $display("FAIL fwd_x0 got %b exp 00", fwd_rs2); end
        div_wb_rd = 7;
        @(negedge clk);
        idle();
    endtask

    task automatic test_div_full();
        do_reset();
        issue(1);
        issue(2);
        div_d = 1'b1;
        #1;
        n_chk++; if (div_full !== 1'b1) begin n_fail++; $display("FAIL full_flag got %b exp 1", div_full); end
        n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL full_stall got %b exp 1", stall); end
        div_wb_valid = 1'b1; div_wb_rd = 1;
        #1;
        n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL full_wb_cycle got %b exp 1", stall); end
        @(negedge clk);
        div_wb_valid = 1'b0;
        #1;
        n_chk++; if (stall !== 1'b0 || div_full !== 1'b0) begin n_fail++; $display("FAIL full_release got %b%b exp 00", stall, div_full); end
        idle(); div_wb_valid = 1'b1; div_wb_rd = 2;
        @(negedge clk);
        idle();
    endtask

    task automatic test_load_use();
        do_reset();
        load_e = 1'b1; rd_e = 3; rs1_d = 3; rs1_used_d = 1'b1;
        #1;
        n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_rs1 got %b exp 1", stall); end
        @(negedge clk);
        load_e = 1'b0;
        #1;
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_release got %b exp 0", stall); end
        load_e = 1'b1; rd_e = 0; rs1_d = 0;
        #1;
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_x0 got %b exp 0", stall); end
        rd_e = 3; rs1_d = 1; rs2_d = 3; rs2_used_d = 1'b1;
        #1;
        n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_rs2 got %b exp 1", stall); end
        rs2_used_d = 1'b0;
        #1;
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_unused got %b exp 0", stall); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_sb_err();
        do_reset();
        div_wb_valid = 1'b1; div_wb_rd = 9;
        #1;
        n_chk++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL err_pre got %b exp 0", sb_err); end
        @(negedge clk);
        idle();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if (sb_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky%0d got %b exp 1", i, sb_err); end
            @(negedge clk);
        end
        issue(4);
        #1;
        rst = 1'b1;
        #1;
        n_chk++; if (busy !== '0 || sb_err !== 1'b0) begin n_fail++; $display("FAIL err_async_rst got %h/%b exp 0/0", busy, sb_err); end
        @(negedge clk);
        rst = 1'b0;
        issue(4);
        div_wb_valid = 1'b1; div_wb_rd = 9;
        @(negedge clk);
        idle(); #1;
        n_chk++; if (sb_err !== 1'b1) begin n_fail++; $display("FAIL err_notbusy got %b exp 1", sb_err); end
        do_reset();
        issue(1);
        issue(2);
        #1;
        n_chk++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL err_full_ok got %b exp 0", sb_err); end
        issue(3);
        #1;
        n_chk++; if (sb_err !== 1'b1) begin n_fail++; $display("FAIL err_overflow got %b exp 1", sb_err); end
        @(negedge clk);
    endtask

    task automatic test_same_cycle();
        do_reset();
        issue(5);
        div_issue_e = 1'b1; rd_e = 6; div_wb_valid = 1'b1; div_wb_rd = 5;
        @(negedge clk);
        idle(); #1;
        n_chk++; if (busy !== 32'h40 || div_full !== 1'b0) begin n_fail++; $display("FAIL same_keep got %h/%b exp 00000040/0", busy, div_full); end
        issue(8);
        #1;
        n_chk++; if (div_full !== 1'b1) begin n_fail++; $display("FAIL same_count got %b exp 1", div_full); end
        do_reset();
        issue(5);
        div_issue_e = 1'b1; rd_e = 5; div_wb_valid = 1'b1; div_wb_rd = 5;
        @(negedge clk);
        idle(); #1;
        n_chk++; if (busy !== 32'h20 || sb_err !== 1'b0) begin n_fail++; $display("FAIL set_wins got %h/%b exp 00000020/0", busy, sb_err); end
        @(negedge clk);
    endtask

    task automatic test_perf_flush();
        do_reset();
        load_e = 1'b1; rd_e = 3; rs1_d = 3; rs1_used_d = 1'b1; branch_taken = 1'b1;
        #1;
        n_chk++; if (stall !== 1'b1 || flush !== 1'b1) begin n_fail++; $display("FAIL both_ctl got %b%b exp 11", stall, flush); end
        do_reset();
        load_e = 1'b1; rd_e = 3; rs1_d = 3; rs1_used_d = 1'b1;
        repeat (3) @(negedge clk);
        idle(); branch_taken = 1'b1;
        #1;
        n_chk++; if (flush !== 1'b1 || stall !== 1'b0) begin n_fail++; $display("FAIL flush_only got %b%b exp 01", stall, flush); end
        repeat (2) @(negedge clk);
        idle(); #1;
`ifdef HAZARD_PERF_CNT_EN
        n_chk++; if (stall_cnt !== 32'd3) begin n_fail++; $display("FAIL stall_cnt got %0d exp 3", stall_cnt); end
        n_chk++; if (flush_cnt !== 32'd2) begin n_fail++; $display("FAIL flush_cnt got %0d exp 2", flush_cnt); end
`else
        n_chk++; if (stall_cnt !== '0) begin n_fail++; $display("FAIL stall_cnt got %0d exp 0", stall_cnt); end
        n_chk++; if (flush_cnt !== '0) begin n_fail++; $display("FAIL flush_cnt got %0d exp 0", flush_cnt); end
`endif
        @(negedge clk);
    endtask

    function automatic logic [AW-1:0] rr();
        return AW'($urandom_range(7));
    endfunction

    function automatic bit in_pend(input int r);
        foreach (pend[i]) if (pend[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [AW-1:0] rs, input logic used);
        if (!used || rs == 0) return 2'b00;
        if (reg_write_m && rd_m == rs) return 2'b10;
        if (reg_write_w && rd_w == rs) return 2'b01;
        if (div_wb_valid && div_wb_rd == rs) return 2'b11;
        return 2'b00;
    endfunction

    task automatic test_random();
        logic [2**AW-1:0] eb;
        logic raw, est;
        int idx;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            idx = -1;
            {rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_m, rd_w} = {rr(), rr(), rr(), rr(), rr(), rr(), rr()};
            {rs1_used_d, rs2_used_d, reg_write_d, div_d} = 4'($urandom);
            {rs1_used_e, rs2_used_e, reg_write_m, reg_write_w} = 4'($urandom);
            load_e = 1'b0; div_issue_e = 1'b0; div_wb_valid = 1'b0;
            branch_taken = ($urandom_range(4) == 0);
            div_wb_rd = rr();
            if (pend.size() > 0 && $urandom_range(2) == 0) begin
                idx = int'($urandom_range(pend.size() - 1));
                div_wb_valid = 1'b1;
                div_wb_rd = AW'(pend[idx]);
            end
            rd_e = rr();
            if (pend.size() < MAXO && $urandom_range(2) == 0) begin
                while (rd_e != 0 && in_pend(int'(rd_e))) rd_e = rr();
                div_issue_e = 1'b1;
            end else begin
                load_e = $urandom_range(1) == 1;
            end
            eb = '0;
            foreach (pend[i]) if (pend[i] != 0) eb[pend[i]] = 1'b1;
            raw = rd_e != 0 && ((rs1_used_d && rs1_d == rd_e) || (rs2_used_d && rs2_d == rd_e));
            est = ((load_e || div_issue_e) && raw) || (rs1_used_d && eb[rs1_d]) || (rs2_used_d && eb[rs2_d])
                || (reg_write_d && rd_d != 0 && eb[rd_d]) || (div_d && pend.size() == MAXO);
            #1;
            n_chk++; if (stall !== est) begin n_fail++; $display("FAIL rnd_stall c%0d got %b exp %b", c, stall, est); end
            n_chk++; if (flush !== branch_taken) begin n_fail++; $display("FAIL rnd_flush c%0d got %b exp %b", c, flush, branch_taken); end
            n_chk++; if (fwd_rs1 !== exp_fwd(rs1_e, rs1_used_e)) begin n_fail++; $display("FAIL rnd_fwd1 c%0d got %b exp %b", c, fwd_rs1, exp_fwd(rs1_e, rs1_used_e)); end
            n_chk++; if (fwd_rs2 !== exp_fwd(rs2_e, rs2_used_e)) begin n_fail++; $display("FAIL rnd_fwd2 c%0d got %b exp %b", c, fwd_rs2, exp_fwd(rs2_e, rs2_used_e)); end
            n_chk++; if (busy !== eb) begin n_fail++; $display("FAIL rnd_busy c%0d got %h exp %h", c, busy, eb); end
            n_chk++; if (div_full !== (pend.size() == MAXO)) begin n_fail++; $display("FAIL rnd_full c%0d got %b exp %b", c, div_full, pend.size() == MAXO); end
            n_chk++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL rnd_err c%0d got %b exp 0", c, sb_err); end
            if (idx >= 0) pend.delete(idx);
            if (div_issue_e) pend.push_back(int'(rd_e));
            @(negedge clk);
        end
        idle();
    endtask

    initial begin
        idle();
        @(negedge clk);
        test_reset();
        test_div_raw();
        test_fwd();
        test_div_full();
        test_load_use();
        test_sb_err();
        test_same_cycle();
        test_perf_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
